// File: rtl/tsc_pkg.sv
// tsc_pkg: shared state encoding, sample width and pointer-width helper for the transient capture controller
package tsc_pkg;
  localparam int SAMPLE_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_POST, S_HOLD, S_SEND} tsc_state_e;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/tsc_capture_ctrl_ring_buffer.sv
// tsc_ring_buffer: DEPTH x SAMPLE_W sample store, one write port and one registered read port
module tsc_ring_buffer
  import tsc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW = ptr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [SAMPLE_W-1:0] wd,
  input  logic [AW-1:0]       ra,
  output logic [SAMPLE_W-1:0] rd
);
  logic [SAMPLE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/tsc_capture_ctrl.sv
// tsc_capture_ctrl: ADC2 transient capture with pre/post trigger window and serial readout; TSC_ADC_TIMEOUT_EN adds the rdy timeout
module tsc_capture_ctrl
  import tsc_pkg::*;
#(
  parameter int                  BUF_DEPTH   = 32,
  parameter int                  PRE_SAMPLES = 8,
  parameter logic [SAMPLE_W-1:0] TRIG_LEVEL  = 8'd128,
  parameter int                  SAMPLE_DIV  = 4,
  parameter int                  ADC_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  output logic                req,
  input  logic                rdy,
  input  logic [SAMPLE_W-1:0] dat,
  input  logic                sbf,
  output logic                trd,
  output logic                sd,
  output logic                cd,
  output logic                busy,
  output logic                err
);
  localparam int PW = ptr_w(BUF_DEPTH);
  localparam int DW = $clog2(SAMPLE_DIV + 1);
  localparam logic [PW:0] PRE_C = (PW + 1)'(PRE_SAMPLES);
  localparam logic [PW:0] POST_LAST = (PW + 1)'(BUF_DEPTH - PRE_SAMPLES - 2);
  localparam logic [PW:0] SEND_LAST = (PW + 1)'(BUF_DEPTH - 1);
  localparam logic [DW-1:0] DIV_RLD = DW'(SAMPLE_DIV - 1);
  tsc_state_e state_q, state_d;
  logic req_q, req_d, trd_q, trd_d, cd_q, cd_d, we, cap, tmo;
  logic [DW-1:0] div_q, div_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d, rd_data;
  logic [2:0] bit_q, bit_d;
  tsc_ring_buffer #(.DEPTH(BUF_DEPTH), .AW(PW)) u_buf (
    .clk(clk),
    .we (we),
    .wa (wr_ptr_q),
    .wd (dat),
    .ra (rd_ptr_d),
    .rd (rd_data)
  );
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    div_d = div_q;
    cnt_d = cnt_q;
    wr_ptr_d = wr_ptr_q;
    shift_d = shift_q;
    bit_d = bit_q;
    trd_d = trd_q;
    cd_d = 1'b0;
    we = 1'b0;
    cap = req_q & rdy;
    case (state_q)
      S_IDLE: if (start & ~stop) begin
        state_d = S_RUN;
        trd_d = 1'b0;
        cnt_d = '0;
        div_d = '0;
      end
      S_RUN, S_POST: if (cap) begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        req_d = 1'b0;
        div_d = DIV_RLD;
        if (state_q == S_POST) begin
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == POST_LAST) ? S_HOLD : S_POST;
        end else if (cnt_q >= PRE_C && dat >= TRIG_LEVEL) begin
          state_d = S_POST;
          trd_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = (cnt_q < PRE_C) ? cnt_q + 1'b1 : cnt_q;
        end
      end else if (!req_q) begin
        req_d = (div_q == '0);
        div_d = (div_q == '0) ? div_q : div_q - 1'b1;
      end
      S_HOLD: if (sbf) begin
        state_d = S_SEND;
        shift_d = rd_data;
        bit_d = '0;
        cnt_d = '0;
      end
      S_SEND: begin
        bit_d = bit_q + 1'b1;
        shift_d = (bit_q == 3'd7) ? rd_data : {shift_q[SAMPLE_W-2:0], 1'b0};
        cnt_d = (bit_q == 3'd7) ? cnt_q + 1'b1 : cnt_q;
        if (bit_q == 3'd7 && cnt_q == SEND_LAST) begin
          state_d = S_IDLE;
          cd_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      state_d = S_IDLE;
      req_d = 1'b0;
    end
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      req_d = 1'b0;
      cd_d = 1'b0;
    end
    rd_ptr_d = (state_d != S_SEND) ? wr_ptr_d : (state_q != S_SEND || bit_q == 3'd7) ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q <= 1'b0;
      div_q <= '0;
      cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      shift_q <= '0;
      bit_q <= '0;
      trd_q <= 1'b0;
      cd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      trd_q <= trd_d;
      cd_q <= cd_d;
    end
  end
`ifdef TSC_ADC_TIMEOUT_EN
  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic err_q, err_d;
  always_comb begin
    to_d = (req_q & ~rdy) ? to_q + 1'b1 : '0;
    tmo = req_q & ~rdy & (to_q == TW'(ADC_TIMEOUT - 1));
    err_d = (state_q == S_IDLE && start && !stop) ? 1'b0 : err_q | tmo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
      err_q <= 1'b0;
    end else begin
      to_q <= to_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  assign req = req_q;
  assign trd = trd_q;
  assign cd = cd_q;
  assign sd = (state_q == S_SEND) & shift_q[SAMPLE_W-1];
  assign busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_tsc_capture_ctrl.sv
// tb_tsc_capture_ctrl: randomized ADC2 responder checked against a window/stream reference model
module tb_tsc_capture_ctrl;
  localparam int DEPTH = 32;
  localparam int PRE = 8;
  localparam int POST_N = DEPTH - PRE - 1;
  localparam int DIV = 4;
  localparam logic [7:0] TRIG = 8'd128;
  logic clk = 1'b0, rst, start, stop, req, rdy, sbf, trd, sd, cd, busy, err;
  logic [7:0] dat;
  logic [7:0] src [256];
  int n_chk = 0, n_err = 0;
  int ncap = 0, low = 0, gap_n = 0, gap_bad = 0;
  bit have_cap = 0, prev_req = 0, rdy_off = 0;
  tsc_capture_ctrl #(
    .BUF_DEPTH(DEPTH), .PRE_SAMPLES(PRE), .TRIG_LEVEL(TRIG), .SAMPLE_DIV(DIV), .ADC_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .req(req), .rdy(rdy), .dat(dat),
    .sbf(sbf), .trd(trd), .sd(sd), .cd(cd), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic int trig_at();
    for (int k = PRE; k < 256; k++) if (src[k] >= TRIG) return k;
    return -1;
  endfunction
  initial begin
    rdy = 1'b0;
    dat = '0;
    forever begin
      @(negedge clk);
      if (!busy) have_cap = 0;
      if (req && !prev_req && have_cap) begin
        gap_n++;
        if (low != DIV) gap_bad++;
      end
      if (!req) low++;
      dat = src[ncap % 256];
      rdy = rdy_off ? 1'b0 : req ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      if (req && rdy) begin
        ncap++;
        have_cap = 1;
        low = 0;
      end
      prev_req = req;
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic begin_run();
    gap_bad = 0;
    gap_n = 0;
    ncap = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("run_busy", busy, 1);
    check("run_trd_clr", trd, 0);
    check("req_entry0", req, 0);
    @(negedge clk);
    check("req_entry1", req, 1);
  endtask
  task automatic wait_caps(input int n);
    for (int i = 0; i < 4000 && ncap < n; i++) @(negedge clk);
    check("ncap", ncap, n);
  endtask
  task automatic capture_hold(input int t);
    begin_run();
    wait_caps(t + 1 + POST_N);
    repeat (30) @(negedge clk);
    check("hold_ncap", ncap, t + 1 + POST_N);
    check("hold_req", req, 0);
    check("hold_busy", busy, 1);
    check("hold_trd", trd, 1);
    check("gap_bad", gap_bad, 0);
    check("gap_n", gap_n, t + POST_N);
    check("err_idle", err, 0);
  endtask
  task automatic send_check(input int t);
    int bad_cd;
    logic [7:0] b;
    bad_cd = 0;
    @(negedge clk) sbf = 1'b1;
    @(negedge clk) sbf = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        b = {b[6:0], sd};
        bad_cd += int'(cd);
        @(negedge clk);
      end
      check("byte", b, src[t - PRE + s]);
    end
    check("cd_early", bad_cd, 0);
    check("cd_pulse", cd, 1);
    check("cd_sd", sd, 0);
    check("cd_busy", busy, 0);
    check("cd_trd", trd, 1);
    @(negedge clk);
    check("cd_end", cd, 0);
  endtask
  task automatic full_run();
    int t;
    t = trig_at();
    capture_hold(t);
    send_check(t);
  endtask
  initial begin
    int seen;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    sbf = 1'b0;
    for (int k = 0; k < 256; k++) src[k] = 8'(k * 10);
    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_trd", trd, 0);
    check("rst_sd", sd, 0);
    check("rst_cd", cd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    check("stop_wins", busy, 0);
    check("ramp_trig", trig_at(), 13);
    full_run();
    for (int k = 0; k < 256; k++) src[k] = 8'((k * 7) % 120);
    src[3] = 8'd200;
    begin_run();
    wait_caps(40);
    check("notrig_trd", trd, 0);
    check("notrig_busy", busy, 1);
    check("notrig_gap", gap_bad, 0);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check("notrig_stop", busy, 0);
    for (int k = 0; k < 256; k++) src[k] = 8'(k * 10);
    begin_run();
    wait_caps(20);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check("post_stop_busy", busy, 0);
    check("post_stop_req", req, 0);
    check("post_stop_trd", trd, 1);
    @(negedge clk) sbf = 1'b1;
    @(negedge clk) sbf = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      seen += int'(cd) + int'(busy);
    end
    check("post_stop_sbf", seen, 0);
    for (int k = 0; k < 256; k++) src[k] = 8'($urandom_range(0, 255));
    src[60] = 8'd255;
    full_run();
    for (int k = 0; k < 256; k++) src[k] = 8'(k * 10);
    capture_hold(trig_at());
    @(negedge clk) sbf = 1'b1;
    @(negedge clk) sbf = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", req, 0);
    check("mid_rst_trd", trd, 0);
    check("mid_rst_sd", sd, 0);
    check("mid_rst_cd", cd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) src[k] = 8'($urandom_range(0, 255));
    src[40] = 8'd128;
    full_run();
`ifdef TSC_ADC_TIMEOUT_EN
    rdy_off = 1;
    begin_run();
    repeat (63) @(negedge clk);
    check("to_before", err, 0);
    @(negedge clk);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_req", req, 0);
    rdy_off = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
